// File: rtl/operation_pkg.sv
// Shared operation definitions for the command controller and the executor.
//   operation_t   : 3-bit opcode set, INVALID (3'b111) marks "no operation".
//   issue_state_t : controller FSM states.
//   OP_IDLE_CODE  : opcode driven to the executor whenever nothing is issued.
package operation_pkg;

  typedef enum logic [2:0] {
    ADD     = 3'b000,
    SUB     = 3'b001,
    MUL     = 3'b010,
    DIV     = 3'b011,
    AND_OP  = 3'b100,
    OR_OP   = 3'b101,
    XOR_OP  = 3'b110,
    INVALID = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } issue_state_t;

  localparam operation_t OP_IDLE_CODE = INVALID;

endpackage

// File: rtl/op_issue_timer.sv
// Loadable 4-bit down-counter timing the executor latency.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (takes priority over counting)
//   load_val     : value to load
//   last         : counter currently holds 1 (final latency cycle)
module op_issue_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] cnt;

  // Counts down to 0 and parks there until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign last = (cnt == 4'd1);

endmodule

// File: rtl/op_issue_ctrl.sv
// Command-side controller for the operation executor. Accepts one command at a
// time, drives it to the executor for EXEC_LAT cycles, captures the result and
// returns it with an error flag.
// Optional feature macro: OP_ISSUE_DIV0_CHECK_EN -- when defined, DIV with a
// zero divisor is rejected locally (rsp_data all ones, rsp_err=1, not issued).
//   clk, reset_n                  : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_op, cmd_a, cmd_b          : command opcode and operands
//   op_code, opnd_a, opnd_b       : executor inputs (INVALID/0 unless in WAIT)
//   exe_result                    : executor result
//   rsp_valid/rsp_ready           : response handshake
//   rsp_data, rsp_err             : captured result and error flag
//   issue_cnt                     : number of operations sent to the executor
module op_issue_ctrl
  import operation_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int EXEC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [2:0]        op_code,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  input  logic [DATA_W-1:0] exe_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [15:0]       issue_cnt
);

  if (EXEC_LAT < 1 || EXEC_LAT > 15) begin : g_lat_check
    $error("EXEC_LAT must be in 1..15");
  end

  issue_state_t      state_q, state_d;
  operation_t        cmd_op_t, op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              accept, reject, div0, issue, capture, last;

  assign cmd_op_t = operation_t'(cmd_op);

`ifdef OP_ISSUE_DIV0_CHECK_EN
  assign div0 = (cmd_op_t == DIV) && (cmd_b == '0);
`else
  assign div0 = 1'b0;
`endif

  assign reject = (cmd_op_t == INVALID) || div0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = reject ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (last) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        // Return to IDLE only; cmd_ready rises the cycle after the handshake.
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue = accept && !reject;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_IDLE_CODE;
      a_q       <= '0;
      b_q       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      issue_cnt <= 16'd0;
    end else if (accept) begin
      op_q <= cmd_op_t;
      a_q  <= cmd_a;
      b_q  <= cmd_b;
      if (reject) begin
        rsp_data <= div0 ? '1 : '0;
        rsp_err  <= 1'b1;
      end else begin
        issue_cnt <= issue_cnt + 16'd1;
      end
    end else if (capture) begin
      rsp_data <= exe_result;
      rsp_err  <= 1'b0;
    end
  end

  // Executor sees the latched command only while an operation is in flight.
  assign op_code = (state_q == WAIT) ? op_q : OP_IDLE_CODE;
  assign opnd_a  = (state_q == WAIT) ? a_q  : '0;
  assign opnd_b  = (state_q == WAIT) ? b_q  : '0;

  op_issue_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (issue),
    .load_val (4'(EXEC_LAT)),
    .last     (last)
  );

endmodule
